// File: rtl/seven_segment_scanner_if.sv
// seven_segment_scanner_if: frame-load inputs and display pin outputs of the scanner
interface seven_segment_scanner_if #(parameter int N_DIGITS = 8);
  logic                  load;
  logic [4*N_DIGITS-1:0] number;
  logic [N_DIGITS-1:0]   dots;
  logic [N_DIGITS-1:0]   blank;
  logic [7:0]            abcdefgh;
  logic [N_DIGITS-1:0]   digit;
  logic                  frame_start;
  modport master (output load, number, dots, blank, input abcdefgh, digit, frame_start);
  modport slave  (input load, number, dots, blank, output abcdefgh, digit, frame_start);
endinterface

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: double-buffered hex frame scanned across a multiplexed 7-segment display
module seven_segment_scanner #(
  parameter int N_DIGITS         = 8,
  parameter int SCAN_CYCLES      = 50000,
  parameter int GUARD_CYCLES     = 16,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst_n,
  seven_segment_scanner_if.slave bus
);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_CYCLES);
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] DIG_OFF = DIGIT_ACTIVE_LOW != 0 ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  // Glyph for nibble n lives at bits [8n+7:8n], active-high, a at bit 7
  localparam logic [127:0] FONT = 128'h8E9E7A9C3EEEF6FE_E0BEB666F2DA60FC;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  pend_q, pend_d;
  logic [4*N_DIGITS-1:0] pnum_q, pnum_d, anum_q, anum_d;
  logic [N_DIGITS-1:0]   pdots_q, pdots_d, adots_q, adots_d;
  logic [N_DIGITS-1:0]   pblank_q, pblank_d, ablank_q, ablank_d;
  logic [7:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   dig_q, dig_d;
  logic                  fs_q, fs_d;
  logic                  cnt_last, idx_last, frame_end, take_in, take_pend, dark;
  logic [3:0]            nib;
  logic [7:0]            glyph;
  logic [N_DIGITS-1:0]   onehot;

  always_comb begin
    cnt_last  = cnt_q == CW'(SCAN_CYCLES - 1);
    idx_last  = idx_q == IW'(N_DIGITS - 1);
    frame_end = cnt_last && idx_last;
    cnt_d     = cnt_last ? '0 : cnt_q + CW'(1);
    idx_d     = cnt_last ? (idx_last ? '0 : idx_q + IW'(1)) : idx_q;
    // A load on the frame-end clock bypasses the pending buffer entirely
    take_in   = frame_end && bus.load;
    take_pend = frame_end && pend_q;
    pend_d    = frame_end ? 1'b0 : (bus.load || pend_q);
    pnum_d    = bus.load ? bus.number : pnum_q;
    pdots_d   = bus.load ? bus.dots : pdots_q;
    pblank_d  = bus.load ? bus.blank : pblank_q;
    anum_d    = take_in ? bus.number : take_pend ? pnum_q : anum_q;
    adots_d   = take_in ? bus.dots : take_pend ? pdots_q : adots_q;
    ablank_d  = take_in ? bus.blank : take_pend ? pblank_q : ablank_q;
    nib       = anum_q[{idx_q, 2'b00} +: 4];
    glyph     = FONT[{nib, 3'b000} +: 8] | {7'b0, adots_q[idx_q]};
    onehot    = N_DIGITS'(1) << idx_q;
    dark      = cnt_q < CW'(GUARD_CYCLES) || ablank_q[idx_q];
    seg_d     = dark ? SEG_OFF : (SEG_ACTIVE_LOW != 0 ? ~glyph : glyph);
    dig_d     = dark ? DIG_OFF : (DIGIT_ACTIVE_LOW != 0 ? ~onehot : onehot);
    fs_d      = cnt_q == '0 && idx_q == '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      pnum_q   <= '0;
      pdots_q  <= '0;
      pblank_q <= '1;
      anum_q   <= '0;
      adots_q  <= '0;
      ablank_q <= '1;
      seg_q    <= SEG_OFF;
      dig_q    <= DIG_OFF;
      fs_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      pnum_q   <= pnum_d;
      pdots_q  <= pdots_d;
      pblank_q <= pblank_d;
      anum_q   <= anum_d;
      adots_q  <= adots_d;
      ablank_q <= ablank_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      fs_q     <= fs_d;
    end
  end

  assign bus.abcdefgh    = seg_q;
  assign bus.digit       = dig_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: random and directed frames checked cycle by cycle against a frame-level model
module tb_seven_segment_scanner;
  localparam int N = 4, S = 8, G = 2, FRAME = N * S;

  logic clk = 1'b0, rst_n = 1'b0;
  seven_segment_scanner_if #(.N_DIGITS(N)) bus ();

  seven_segment_scanner #(
    .N_DIGITS(N), .SCAN_CYCLES(S), .GUARD_CYCLES(G),
    .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int tick;
  logic [15:0] m_anum, m_pnum;
  logic [3:0]  m_adots, m_pdots, m_ablank, m_pblank;
  bit          m_pflag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] font(input int v);
    case (v)
      0: return 8'hFC;  1: return 8'h60;  2: return 8'hDA;  3: return 8'hF2;
      4: return 8'h66;  5: return 8'hB6;  6: return 8'hBE;  7: return 8'hE0;
      8: return 8'hFE;  9: return 8'hF6;  10: return 8'hEE; 11: return 8'h3E;
      12: return 8'h9C; 13: return 8'h7A; 14: return 8'h9E; default: return 8'h8E;
    endcase
  endfunction

  task automatic model_reset();
    tick = 0;
    m_pflag = 0;
    m_anum = 0; m_adots = 0; m_ablank = 4'hF;
    m_pnum = 0; m_pdots = 0; m_pblank = 4'hF;
  endtask

  // One clock: expected pins come from the model position before the edge, then the model absorbs load
  task automatic step(input bit ld, input logic [15:0] num, input logic [3:0] dt, input logic [3:0] bl);
    int p, i, c;
    bit dark;
    logic [7:0] e_seg;
    logic [3:0] e_dig;
    bit e_fs;
    bus.load = ld; bus.number = num; bus.dots = dt; bus.blank = bl;
    p = tick % FRAME; i = p / S; c = p % S;
    dark  = (c < G) || m_ablank[i];
    e_dig = dark ? 4'hF : ~(4'(1) << i);
    e_seg = dark ? 8'hFF : ~(font(int'((m_anum >> (4 * i)) & 16'hF)) | {7'b0, m_adots[i]});
    e_fs  = (p == 0);
    if (ld) begin
      m_pnum = num; m_pdots = dt; m_pblank = bl; m_pflag = 1;
    end
    if (p == FRAME - 1) begin
      if (ld) begin
        m_anum = num; m_adots = dt; m_ablank = bl;
      end else if (m_pflag) begin
        m_anum = m_pnum; m_adots = m_pdots; m_ablank = m_pblank;
      end
      m_pflag = 0;
    end
    tick++;
    @(posedge clk);
    #1;
    check("digit", 32'(bus.digit), 32'(e_dig));
    check("abcdefgh", 32'(bus.abcdefgh), 32'(e_seg));
    check("frame_start", 32'(bus.frame_start), 32'(e_fs));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic idle_until(input int pos);
    while (tick % FRAME != pos) step(0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.load = 1'b1;
    #1;
    check("rst_digit", 32'(bus.digit), 32'hF);
    check("rst_seg", 32'(bus.abcdefgh), 32'hFF);
    check("rst_fs", 32'(bus.frame_start), 32'h0);
    repeat (3) @(negedge clk);
    check("rst_hold_digit", 32'(bus.digit), 32'hF);
    check("rst_hold_seg", 32'(bus.abcdefgh), 32'hFF);
    bus.load = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.load = 0; bus.number = 0; bus.dots = 0; bus.blank = 0;
    hard_reset();
    idle(3 * FRAME);
    step(1, 16'h3210, 4'b0100, 4'b0000);
    idle(2 * FRAME);
    idle_until(5);
    step(1, 16'hFEDC, 4'b0000, 4'b0000);
    idle(7);
    step(1, 16'hBA98, 4'b0000, 4'b0000);
    idle(2 * FRAME);
    idle_until(FRAME - 1);
    step(1, 16'h7777, 4'b0000, 4'b0000);
    idle(2 * FRAME);
    step(1, 16'h4321, 4'b1111, 4'b1010);
    idle(2 * FRAME);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0)
        step(1, 16'($urandom), 4'($urandom_range(0, 15)),
             $urandom_range(0, 2) == 0 ? 4'($urandom_range(0, 15)) : 4'h0);
      else
        step(0, 16'h0, 4'h0, 4'h0);
    end
    idle_until(2 * S + 1);
    step(1, 16'h5555, 4'b0000, 4'b0000);
    idle(2);
    hard_reset();
    idle(2 * FRAME);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
